// File: rtl/mode_selector_if.sv
// Button/lock inputs and mode outputs of the mode controller, bundled as one port.
// slave = controller side, master = the logic that drives the button and consumes the mode.
interface mode_selector_if #(
  parameter int NUM_MODES = 2,
  parameter int MODE_W    = 1
);
  logic                 mode_btn;
  logic                 mode_lock;
  logic [MODE_W-1:0]    mode;
  logic [NUM_MODES-1:0] mode_onehot;
  logic                 mode_chg;
  logic                 led_mode;

  modport master (
    output mode_btn, mode_lock,
    input  mode, mode_onehot, mode_chg, led_mode
  );

  modport slave (
    input  mode_btn, mode_lock,
    output mode, mode_onehot, mode_chg, led_mode
  );
endinterface

// File: rtl/mode_selector.sv
// Push-button mode controller: synchronise, debounce on a divided tick, cycle through NUM_MODES.
// Define LONG_PRESS_EN to advance on release and return to mode 0 on a long hold.
module mode_selector #(
  parameter int NUM_MODES = 2,
  parameter int MODE_W    = 1,
  parameter int TICK_DIV  = 100000,
  parameter int DEB_CNT   = 20,
  parameter int LONG_CNT  = 1000
) (
  input  logic           clk,
  input  logic           rst,
  mode_selector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_DONE
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  if (NUM_MODES < 2 || NUM_MODES > (1 << MODE_W) || TICK_DIV < 1 ||
      DEB_CNT < 1 || LONG_CNT < 1) begin : g_bad_params
    $error("mode_selector: parameter out of range");
  end

  // Two-flop synchroniser; the raw button only ever feeds sync_q1.
  logic sync_q1, sync_q2;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bus.mode_btn;
      sync_q2 <= sync_q1;
    end
  end

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  // A new level is accepted only after DEB_CNT consecutive ticks that disagree with it.
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (tick) begin
      if (sync_q2 != deb_level) begin
        if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
          deb_level <= sync_q2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  logic deb_prev;
  logic armed;
  logic press;
  logic release_evt;
  logic press_ok;

  assign press       = deb_level & ~deb_prev;
  assign release_evt = ~deb_level & deb_prev;
  assign press_ok    = press & armed;

  // A button held through reset must be seen released before it can count as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (release_evt || (tick && !sync_q2 && !deb_level)) begin
        armed <= 1'b1;
      end
    end
  end

  state_t state, state_nx;
  logic   do_adv;
  logic   do_zero;

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // Saturates at LONG_CNT so a very long hold cannot wrap back into short-press range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state != HELD) begin
      hold_cnt <= '0;
    end else if (tick && (hold_cnt != HOLD_W'(LONG_CNT))) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: defaults first, so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_nx = state;
    do_adv   = 1'b0;
    do_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (press_ok) begin
          state_nx = HELD;
`ifndef LONG_PRESS_EN
          do_adv   = ~bus.mode_lock;
`endif
        end
      end
      HELD: begin
`ifdef LONG_PRESS_EN
        if (release_evt) begin
          state_nx = IDLE;
          do_adv   = ~bus.mode_lock & (hold_cnt < HOLD_W'(LONG_CNT));
        end else if (hold_cnt == HOLD_W'(LONG_CNT)) begin
          state_nx = LONG_DONE;
          do_zero  = ~bus.mode_lock;
        end
`else
        if (release_evt) begin
          state_nx = IDLE;
        end
`endif
      end
      LONG_DONE: begin
        if (release_evt) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [MODE_W-1:0] mode_nx;
  assign mode_nx = (bus.mode == LAST_MODE) ? '0 : bus.mode + 1'b1;

  // All four outputs are registered together so they change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mode        <= '0;
      bus.mode_onehot <= NUM_MODES'(1);
      bus.led_mode    <= 1'b0;
      bus.mode_chg    <= 1'b0;
    end else if (do_zero) begin
      bus.mode        <= '0;
      bus.mode_onehot <= NUM_MODES'(1);
      bus.led_mode    <= 1'b0;
      bus.mode_chg    <= (bus.mode != '0);
    end else if (do_adv) begin
      bus.mode        <= mode_nx;
      bus.mode_onehot <= NUM_MODES'(1) << mode_nx;
      bus.led_mode    <= (mode_nx != '0);
      bus.mode_chg    <= 1'b1;
    end else begin
      bus.mode_chg    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_selector.sv
// Self-checking bench for mode_selector: directed scenarios plus randomized presses
// checked against a press-counting reference model. Builds with or without LONG_PRESS_EN.
module tb_mode_selector;
  localparam int NUM_MODES = 3;
  localparam int MODE_W    = 2;
  localparam int TICK_DIV  = 4;
  localparam int DEB_CNT   = 3;
  localparam int LONG_CNT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mode_selector_if #(.NUM_MODES(NUM_MODES), .MODE_W(MODE_W)) bus ();

  mode_selector #(
    .NUM_MODES(NUM_MODES),
    .MODE_W   (MODE_W),
    .TICK_DIV (TICK_DIV),
    .DEB_CNT  (DEB_CNT),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int chg_cnt      = 0;
  int wide_cnt     = 0;
  int last_chg_cyc = 0;
  bit prev_chg     = 1'b0;
  int exp_mode     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts mode_chg pulses and flags any pulse wider than one clock.
  always @(negedge clk) begin
    if (bus.mode_chg === 1'b1) begin
      chg_cnt++;
      last_chg_cyc = cyc;
      if (prev_chg) wide_cnt++;
    end
    prev_chg = (bus.mode_chg === 1'b1);
  end

  // Reference: mode advances modulo NUM_MODES; outputs packed as {mode, onehot, led}.
  function automatic int next_mode(int m);
    return (m + 1) % NUM_MODES;
  endfunction

  function automatic logic [5:0] exp_outputs(int m);
    logic [1:0] mb;
    logic [2:0] oh;
    mb = m[1:0];
    oh = 3'b001 << m;
    return {mb, oh, (m != 0)};
  endfunction

  function automatic logic [5:0] got_outputs();
    return {bus.mode, bus.mode_onehot, bus.led_mode};
  endfunction

  task automatic press_release(int hold, int rel);
    @(negedge clk);
    bus.mode_btn = 1'b1;
    repeat (hold) @(negedge clk);
    bus.mode_btn = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.mode_btn  = 1'b0;
    bus.mode_lock = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (got_outputs() !== exp_outputs(0) || bus.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got %b chg %b expected %b chg 0", got_outputs(), bus.mode_chg, exp_outputs(0));
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (got_outputs() !== exp_outputs(0) || chg_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle: got %b pulses %0d expected %b pulses 0", got_outputs(), chg_cnt, exp_outputs(0));
    end
  endtask

  task automatic test_wrap();
    int c;
    for (int i = 0; i < 3; i++) begin
      c = chg_cnt;
      press_release(40, 40);
      exp_mode = next_mode(exp_mode);
      checks++;
      if (got_outputs() !== exp_outputs(exp_mode)) begin
        failures++;
        $display("FAIL wrap_outputs[%0d]: got %b expected %b", i, got_outputs(), exp_outputs(exp_mode));
      end
      checks++;
      if (chg_cnt - c !== 1) begin
        failures++;
        $display("FAIL wrap_pulses[%0d]: got %0d expected 1", i, chg_cnt - c);
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      failures++;
      $display("FAIL wrap_pulse_width: got %0d wide pulses expected 0", wide_cnt);
    end
  endtask

  task automatic test_bounce();
    int c;
    int t0;
    c = chg_cnt;
    @(negedge clk);
    repeat (12) begin
      bus.mode_btn = ~bus.mode_btn;
      repeat (5) @(negedge clk);
    end
    checks++;
    if (chg_cnt !== c) begin
      failures++;
      $display("FAIL bounce_rejected: got %0d pulses expected 0", chg_cnt - c);
    end
    bus.mode_btn = 1'b1;
    t0 = cyc;
    repeat (40) @(negedge clk);
`ifndef LONG_PRESS_EN
    checks++;
    if (chg_cnt - c !== 1) begin
      failures++;
      $display("FAIL bounce_one_advance: got %0d pulses expected 1", chg_cnt - c);
    end
    checks++;
    if (last_chg_cyc - t0 < 12 || last_chg_cyc - t0 > 16) begin
      failures++;
      $display("FAIL bounce_latency: got %0d clk expected 12..16", last_chg_cyc - t0);
    end
`endif
    bus.mode_btn = 1'b0;
    repeat (40) @(negedge clk);
    exp_mode = next_mode(exp_mode);
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(exp_mode)) begin
      failures++;
      $display("FAIL bounce_result: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(exp_mode));
    end
  endtask

  task automatic test_lock();
    int c;
    c = chg_cnt;
    bus.mode_lock = 1'b1;
    press_release(40, 40);
    checks++;
    if (chg_cnt !== c || got_outputs() !== exp_outputs(exp_mode)) begin
      failures++;
      $display("FAIL lock_ignored: got %b pulses %0d expected %b pulses 0", got_outputs(), chg_cnt - c, exp_outputs(exp_mode));
    end
    bus.mode_lock = 1'b0;
    press_release(40, 40);
    exp_mode = next_mode(exp_mode);
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(exp_mode)) begin
      failures++;
      $display("FAIL lock_released: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(exp_mode));
    end
  endtask

  task automatic goto_mode(int target);
    for (int i = 0; i < NUM_MODES && exp_mode != target; i++) begin
      press_release(40, 40);
      exp_mode = next_mode(exp_mode);
    end
    checks++;
    if (got_outputs() !== exp_outputs(target)) begin
      failures++;
      $display("FAIL goto_mode%0d: got %b expected %b", target, got_outputs(), exp_outputs(target));
    end
  endtask

  task automatic test_reset_mid_press();
    int c;
    goto_mode(2);
    @(negedge clk);
    bus.mode_btn = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_mode = 0;
    checks++;
    if (got_outputs() !== exp_outputs(0) || bus.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got %b chg %b expected %b chg 0", got_outputs(), bus.mode_chg, exp_outputs(0));
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c = chg_cnt;
    repeat (40) @(negedge clk);
    bus.mode_btn = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (chg_cnt !== c || got_outputs() !== exp_outputs(0)) begin
      failures++;
      $display("FAIL reset_held_press: got %b pulses %0d expected %b pulses 0", got_outputs(), chg_cnt - c, exp_outputs(0));
    end
    press_release(40, 40);
    exp_mode = next_mode(exp_mode);
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(exp_mode)) begin
      failures++;
      $display("FAIL reset_new_press: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(exp_mode));
    end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long_press();
    int c;
    goto_mode(2);
    c = chg_cnt;
    @(negedge clk);
    bus.mode_btn = 1'b1;
    repeat (60) @(negedge clk);
    exp_mode = 0;
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(0)) begin
      failures++;
      $display("FAIL long_forced_zero: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(0));
    end
    bus.mode_btn = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(0)) begin
      failures++;
      $display("FAIL long_release: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(0));
    end
    c = chg_cnt;
    press_release(60, 40);
    checks++;
    if (chg_cnt !== c || got_outputs() !== exp_outputs(0)) begin
      failures++;
      $display("FAIL long_from_zero: got %b pulses %0d expected %b pulses 0", got_outputs(), chg_cnt - c, exp_outputs(0));
    end
  endtask

  task automatic test_short_press();
    int c;
    goto_mode(0);
    c = chg_cnt;
    @(negedge clk);
    bus.mode_btn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (chg_cnt !== c || got_outputs() !== exp_outputs(0)) begin
      failures++;
      $display("FAIL short_while_held: got %b pulses %0d expected %b pulses 0", got_outputs(), chg_cnt - c, exp_outputs(0));
    end
    bus.mode_btn = 1'b0;
    repeat (40) @(negedge clk);
    exp_mode = next_mode(exp_mode);
    checks++;
    if (chg_cnt - c !== 1 || got_outputs() !== exp_outputs(exp_mode)) begin
      failures++;
      $display("FAIL short_after_release: got %b pulses %0d expected %b pulses 1", got_outputs(), chg_cnt - c, exp_outputs(exp_mode));
    end
  endtask
`endif

  task automatic test_random_presses();
    int c;
    bit lk;
    for (int i = 0; i < 10; i++) begin
      c  = chg_cnt;
      lk = ($urandom_range(0, 3) == 0);
      bus.mode_lock = lk;
      press_release($urandom_range(20, 30), $urandom_range(20, 30));
      bus.mode_lock = 1'b0;
      if (!lk) exp_mode = next_mode(exp_mode);
      checks++;
      if (chg_cnt - c !== (lk ? 0 : 1) || got_outputs() !== exp_outputs(exp_mode)) begin
        failures++;
        $display("FAIL random[%0d] lock=%0d: got %b pulses %0d expected %b pulses %0d",
                 i, lk, got_outputs(), chg_cnt - c, exp_outputs(exp_mode), lk ? 0 : 1);
      end
    end
    checks++;
    if (wide_cnt !== 0) begin
      failures++;
      $display("FAIL pulse_width_total: got %0d wide pulses expected 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_bounce();
    test_lock();
    test_reset_mid_press();
`ifdef LONG_PRESS_EN
    test_long_press();
    test_short_press();
`endif
    test_random_presses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_selector.md
Name: mode_selector

Overview:
Parametrised mode controller replacing the fixed two-mode toggle in the decoder/encoder top level. Samples a raw mode push-button, synchronises and debounces it on a divided tick inside the main clock domain, and cycles through NUM_MODES modes on each accepted press. Drives a binary mode, a one-hot mode vector for enabling the decoder/encoder datapaths, a one-cycle change pulse and a mode LED. Supports a lock input. Optional long-press return to mode 0.

Parameters:
NUM_MODES, 2, number of modes, 2..2^MODE_W
MODE_W, 1, width of binary mode output
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz)
DEB_CNT, 20, consecutive ticks of differing input required to accept a new level
LONG_CNT, 1000, ticks held for long press (used only with LONG_PRESS_EN)

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous, active-low reset
mode_btn  in  1  raw push-button, active-high, asynchronous
mode_lock  in  1  synchronous; 1 = ignore presses
mode  out  MODE_W  current mode, binary
mode_onehot  out  NUM_MODES  bit[mode] = 1, all others 0
mode_chg  out  1  one-clk pulse on every mode update
led_mode  out  1  1 when mode != 0

Behaviour:
- Reset (rst low, async): mode=0, mode_onehot=1 (bit0), mode_chg=0, led_mode=0. Synchroniser, tick divider, debounce counter, hold counter and FSM cleared; debounced level=0.
- Reset mid-press: all state cleared; button must be seen released and pressed again after rst deasserts before any advance.
- Sync: 2-FF synchroniser on mode_btn; no logic ever clocked by the button.
- Tick: counter 0..TICK_DIV-1; tick=1 for one clk when it wraps.
- Debounce: on each tick, if sync != deb_level, deb_cnt++; otherwise deb_cnt=0. When deb_cnt reaches DEB_CNT, deb_level<=sync and deb_cnt=0. Glitches shorter than DEB_CNT ticks are rejected.
- press = deb_level 0->1 (one clk); release = 1->0 (one clk).
- Advance: next = (mode==NUM_MODES-1) ? 0 : mode+1. Wraps at NUM_MODES, not at 2^MODE_W.
- mode, mode_onehot, led_mode and mode_chg update on the same clk edge. mode_chg is high exactly one clk per update.
- mode_lock=1 on the cycle of the advance event: event dropped, not queued.
- Latency without macro: advance on the clk edge after press, i.e. 2 clk sync + DEB_CNT ticks after the button settles.
- FSM with states IDLE, HELD, LONG_DONE (full use only with macro):
  - IDLE -> HELD on press.
  - HELD -> IDLE on release.
  - Without macro, HELD is tracking only and the advance fires at press.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
LONG_PRESS_EN
- Defined:
  - Advance moves from press to release: fires on release from HELD only if hold_cnt < LONG_CNT.
  - hold_cnt counts ticks while in HELD.
  - When hold_cnt == LONG_CNT: mode forced to 0. mode_chg pulses only if mode was non-zero. FSM goes HELD -> LONG_DONE.
  - LONG_DONE -> IDLE on release, with no advance.
  - mode_lock also blocks the long-press reset.
- Not defined: no hold counter; advance on press as above; LONG_DONE is unreachable.

Test Plan:
Bench parameters for all tests: NUM_MODES=3, MODE_W=2, TICK_DIV=4, DEB_CNT=3, LONG_CNT=10.
1. Reset: assert rst=0 mid-operation with mode=2 -> mode=0, mode_onehot=3'b001, led_mode=0, mode_chg=0 immediately (async).
2. Wrap: three clean presses, each held 40 clk then released 40 clk -> mode sequence 1,2,0; onehot 010,100,001; exactly three single-clk mode_chg pulses; led_mode 1,1,0.
3. Bounce: toggle mode_btn every 5 clk for 60 clk, then hold high -> exactly one advance, occurring 12-16 clk after the final rising edge.
4. Lock: mode_lock=1 during a clean press -> mode unchanged, no mode_chg. Clear lock, press again -> mode advances by 1.
5. With LONG_PRESS_EN, long press: mode=2, hold 60 clk -> mode=0 with one mode_chg pulse before release; release -> no further change.
6. With LONG_PRESS_EN, short press: mode=0, hold 20 clk -> no change while held; mode=1 and mode_chg after release is debounced.
